// File: rtl/rgmii_rx_frame_align.sv
// RGMII RX frame aligner: strips preamble/SFD, packs 10/100 nibbles into bytes,
// emits framed bytes through a one-byte holder, and debounces in-band link status.
module rgmii_rx_frame_align #(
  parameter int STATUS_DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_rxd,
  output logic       m_rx_valid,
  output logic       m_rx_sof,
  output logic       m_rx_eof,
  output logic       m_rx_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_duplex,
  output logic       status_change,
  output logic       stat_sfd_err,
  output logic       stat_odd_nibble
);

  // Output stream: m_rx_valid marks a byte; sof/eof/err qualify that same beat.
  // There is no backpressure, so a beat is consumed on every cycle it is valid.

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [3:0] DEB = 4'(STATUS_DEBOUNCE);

  state_t     state_q, state_d;
  logic       is_1g_q, is_1g_d;
  logic       phase_q, phase_d;
  logic [3:0] low_nib_q, low_nib_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       first_q, first_d;
  logic       frame_err_q, frame_err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;

  logic [7:0] m_rxd_q, m_rxd_d;
  logic       m_rx_valid_q, m_rx_valid_d;
  logic       m_rx_sof_q, m_rx_sof_d;
  logic       m_rx_eof_q, m_rx_eof_d;
  logic       m_rx_err_q, m_rx_err_d;
  logic       link_up_q, link_up_d;
  logic [1:0] link_speed_q, link_speed_d;
  logic       link_duplex_q, link_duplex_d;
  logic       status_change_q, status_change_d;
  logic       stat_sfd_err_q, stat_sfd_err_d;
  logic       stat_odd_nibble_q, stat_odd_nibble_d;

  // The first preamble symbol is judged with the speed being captured right now.
  logic use_1g, sym_pre, sym_sfd;
  assign use_1g  = (state_q == IDLE) ? speed[1] : is_1g_q;
  assign sym_pre = use_1g ? (gmii_rxd == 8'h55) : (gmii_rxd[3:0] == 4'h5);
  assign sym_sfd = use_1g ? (gmii_rxd == 8'hD5) : (gmii_rxd[3:0] == 4'hD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      is_1g_q           <= 1'b0;
      phase_q           <= 1'b0;
      low_nib_q         <= 4'h0;
      hold_q            <= 8'h00;
      hold_full_q       <= 1'b0;
      first_q           <= 1'b0;
      frame_err_q       <= 1'b0;
      cnt_q             <= 4'h0;
      cand_q            <= 4'h0;
      m_rxd_q           <= 8'h00;
      m_rx_valid_q      <= 1'b0;
      m_rx_sof_q        <= 1'b0;
      m_rx_eof_q        <= 1'b0;
      m_rx_err_q        <= 1'b0;
      link_up_q         <= 1'b0;
      link_speed_q      <= 2'b00;
      link_duplex_q     <= 1'b0;
      status_change_q   <= 1'b0;
      stat_sfd_err_q    <= 1'b0;
      stat_odd_nibble_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      is_1g_q           <= is_1g_d;
      phase_q           <= phase_d;
      low_nib_q         <= low_nib_d;
      hold_q            <= hold_d;
      hold_full_q       <= hold_full_d;
      first_q           <= first_d;
      frame_err_q       <= frame_err_d;
      cnt_q             <= cnt_d;
      cand_q            <= cand_d;
      m_rxd_q           <= m_rxd_d;
      m_rx_valid_q      <= m_rx_valid_d;
      m_rx_sof_q        <= m_rx_sof_d;
      m_rx_eof_q        <= m_rx_eof_d;
      m_rx_err_q        <= m_rx_err_d;
      link_up_q         <= link_up_d;
      link_speed_q      <= link_speed_d;
      link_duplex_q     <= link_duplex_d;
      status_change_q   <= status_change_d;
      stat_sfd_err_q    <= stat_sfd_err_d;
      stat_odd_nibble_q <= stat_odd_nibble_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, PREAMBLE: begin
        if (!gmii_rx_dv)  state_d = IDLE;
        else if (sym_sfd) state_d = DATA;
        else if (sym_pre) state_d = PREAMBLE;
        else              state_d = DROP;
      end
      DATA:    if (!gmii_rx_dv) state_d = IDLE;
      DROP:    if (!gmii_rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic       byte_rdy;
  logic [7:0] new_byte;

  always_comb begin
    is_1g_d           = (state_q == IDLE && gmii_rx_dv) ? speed[1] : is_1g_q;
    phase_d           = phase_q;
    low_nib_d         = low_nib_q;
    hold_d            = hold_q;
    hold_full_d       = hold_full_q;
    first_d           = first_q;
    frame_err_d       = frame_err_q;
    cnt_d             = cnt_q;
    cand_d            = cand_q;
    m_rxd_d           = 8'h00;
    m_rx_valid_d      = 1'b0;
    m_rx_sof_d        = 1'b0;
    m_rx_eof_d        = 1'b0;
    m_rx_err_d        = 1'b0;
    link_up_d         = link_up_q;
    link_speed_d      = link_speed_q;
    link_duplex_d     = link_duplex_q;
    status_change_d   = 1'b0;
    stat_sfd_err_d    = 1'b0;
    stat_odd_nibble_d = 1'b0;
    byte_rdy          = 1'b0;
    new_byte          = gmii_rxd;

    if ((state_q == IDLE || state_q == PREAMBLE) && state_d == DATA) begin
      phase_d     = 1'b0;
      hold_full_d = 1'b0;
      first_d     = 1'b1;
      frame_err_d = 1'b0;
    end
    if (((state_q == IDLE || state_q == PREAMBLE) && state_d == DROP) ||
        (state_q == PREAMBLE && !gmii_rx_dv) ||
        (state_q == DATA && !gmii_rx_dv && !hold_full_q))
      stat_sfd_err_d = 1'b1;

    if (state_q == DATA && gmii_rx_dv) begin
      if (gmii_rx_er) frame_err_d = 1'b1;
      if (is_1g_q) begin
        byte_rdy = 1'b1;
      end else if (!phase_q) begin
        low_nib_d = gmii_rxd[3:0];
        phase_d   = 1'b1;
      end else begin
        byte_rdy = 1'b1;
        new_byte = {gmii_rxd[3:0], low_nib_q};
        phase_d  = 1'b0;
      end
      if (byte_rdy) begin
        if (hold_full_q) begin
          m_rxd_d      = hold_q;
          m_rx_valid_d = 1'b1;
          m_rx_sof_d   = first_q;
          first_d      = 1'b0;
        end
        hold_d      = new_byte;
        hold_full_d = 1'b1;
      end
    end

    // A trailing half byte at 10/100 is dropped and flagged on the eof beat.
    if (state_q == DATA && !gmii_rx_dv && hold_full_q) begin
      m_rxd_d           = hold_q;
      m_rx_valid_d      = 1'b1;
      m_rx_sof_d        = first_q;
      m_rx_eof_d        = 1'b1;
      m_rx_err_d        = frame_err_q | phase_q;
      stat_odd_nibble_d = phase_q;
      hold_full_d       = 1'b0;
      first_d           = 1'b0;
    end
    if (state_d == IDLE) frame_err_d = 1'b0;

    if (state_q == IDLE && !gmii_rx_dv && !gmii_rx_er) begin
      if (cnt_q != 4'h0 && cand_q == gmii_rxd[3:0])
        cnt_d = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
      cand_d = gmii_rxd[3:0];
      if (cnt_d == DEB) begin
        link_up_d       = gmii_rxd[0];
        link_speed_d    = gmii_rxd[2:1];
        link_duplex_d   = gmii_rxd[3];
        status_change_d = {link_up_q, link_speed_q, link_duplex_q} !=
                          {gmii_rxd[0], gmii_rxd[2:1], gmii_rxd[3]};
      end
    end else begin
      cnt_d = 4'h0;
    end
  end

  assign m_rxd           = m_rxd_q;
  assign m_rx_valid      = m_rx_valid_q;
  assign m_rx_sof        = m_rx_sof_q;
  assign m_rx_eof        = m_rx_eof_q;
  assign m_rx_err        = m_rx_err_q;
  assign link_up         = link_up_q;
  assign link_speed      = link_speed_q;
  assign link_duplex     = link_duplex_q;
  assign status_change   = status_change_q;
  assign stat_sfd_err    = stat_sfd_err_q;
  assign stat_odd_nibble = stat_odd_nibble_q;

endmodule
